keycode_das: RTL

KEYCODE_DAS -- requirements
Module: keycode_das

---
 rtl/keycode_das.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/keycode_das.sv
// Keyboard delayed-auto-shift: turns held keycodes into per-channel move/rotate pulses.
// Latency: outputs registered, update one cycle after the sampling frame_tick.
// Backpressure: none; advances only on frame_tick, all other cycles hold state.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame
//   keycode_in     N_SLOTS packed 8-bit keycodes, slot j at [8j+7:8j]
//   act_pulse      one-cycle event per action channel
//   act_held       per-channel held status latched at the last frame_tick
// Optional feature macro: KEYCODE_DAS_OPPOSE_EN (ch0/ch1 pressed together cancel out).
module keycode_das #(
  parameter int N_SLOTS     = 4,
  parameter int N_ACT       = 5,
  parameter     ACT_CODES   = 40'h0E0D160704,
  parameter     REPEAT_MASK = 5'b00111,
  parameter int DAS_INIT    = 16,
  parameter int DAS_REPEAT  = 6,
  parameter int CNT_W       = 5
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 frame_tick,
  input  logic [N_SLOTS*8-1:0] keycode_in,
  output logic [N_ACT-1:0]     act_pulse,
  output logic [N_ACT-1:0]     act_held
);

  // Parameter sanity
  if (DAS_INIT < 2 || DAS_INIT >= (1 << CNT_W)) begin : g_bad_init
    $error("keycode_das: DAS_INIT must be >= 2 and < 2**CNT_W");
  end
  if (DAS_REPEAT < 1 || DAS_REPEAT >= (1 << CNT_W)) begin : g_bad_repeat
    $error("keycode_das: DAS_REPEAT must be >= 1 and < 2**CNT_W");
  end
  if ($bits(ACT_CODES) != N_ACT*8) begin : g_bad_codes
    $error("keycode_das: ACT_CODES must be N_ACT*8 bits wide");
  end

  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(DAS_INIT);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(DAS_REPEAT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [N_ACT-1:0] RMASK  = N_ACT'(REPEAT_MASK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  logic [7:0]       code_w [N_ACT];
  logic [N_ACT-1:0] match_raw;
  logic [N_ACT-1:0] kill;
  logic [N_ACT-1:0] match;

  state_t           state_q [N_ACT];
  state_t           state_d [N_ACT];
  logic [CNT_W-1:0] cnt_q   [N_ACT];
  logic [CNT_W-1:0] cnt_d   [N_ACT];
  logic [N_ACT-1:0] pulse_d;
  logic [N_ACT-1:0] pulse_q;
  logic [N_ACT-1:0] held_q;

  for (genvar g = 0; g < N_ACT; g++) begin : g_code
    assign code_w[g] = ACT_CODES[8*g +: 8];
  end

  // A code of 0x00 marks a disabled channel; duplicates across slots still give one match.
  always_comb begin
    match_raw = '0;
    for (int i = 0; i < N_ACT; i++) begin
      for (int j = 0; j < N_SLOTS; j++) begin
        if (code_w[i] != 8'h00 && keycode_in[8*j +: 8] == code_w[i]) begin
          match_raw[i] = 1'b1;
        end
      end
    end
  end

`ifdef KEYCODE_DAS_OPPOSE_EN
  // Left and right together are treated as neither being pressed.
  if (N_ACT >= 2) begin : g_oppose
    assign kill = {N_ACT{match_raw[0] & match_raw[1]}} & N_ACT'(3);
  end else begin : g_no_oppose
    assign kill = '0;
  end
`else
  assign kill = '0;
`endif

  assign match = match_raw & ~kill;

  // Next-state for every channel FSM; only committed on frame_tick.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < N_ACT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (match[i]) begin
            pulse_d[i] = 1'b1;
            if (RMASK[i]) begin
              state_d[i] = DELAY;
              cnt_d[i]   = INIT_C;
            end else begin
              state_d[i] = LOCK;
            end
          end
        end
        DELAY, REPEAT: begin
          if (!match[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == ONE_C) begin
            pulse_d[i] = 1'b1;
            state_d[i] = REPEAT;
            cnt_d[i]   = REP_C;
          end else begin
            cnt_d[i] = cnt_q[i] - ONE_C;
          end
        end
        LOCK: begin
          if (!match[i]) begin
            state_d[i] = IDLE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < N_ACT; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      // Pulse register clears on every non-tick cycle so events are one cycle wide.
      pulse_q <= frame_tick ? pulse_d : '0;
      if (frame_tick) begin
        for (int i = 0; i < N_ACT; i++) begin
          state_q[i] <= state_d[i];
          cnt_q[i]   <= cnt_d[i];
        end
        held_q <= match;
      end
    end
  end

  assign act_pulse = pulse_q;
  assign act_held  = held_q;

endmodule
